// File: rtl/trap_pkg.sv
// Shared types, cause codes, mstatus bit positions and mstatus update helpers
// for the machine-mode trap sequencer.
package trap_pkg;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ENTER    = 2'd1,
      S_RETURN   = 2'd2,
      S_REDIRECT = 2'd3
   } trap_state_e;

   // interrupt cause codes (mcause[4:0] with interrupt bit set)
   localparam logic [4:0] CAUSE_MEI     = 5'd11;
   localparam logic [4:0] CAUSE_MSI     = 5'd3;
   localparam logic [4:0] CAUSE_MTI     = 5'd7;

   // exception cause codes
   localparam logic [4:0] CAUSE_ILLEGAL = 5'd2;
   localparam logic [4:0] CAUSE_ECALL_U = 5'd8;
   localparam logic [4:0] CAUSE_ECALL_M = 5'd11;

   localparam int MSTAT_MIE    = 3;
   localparam int MSTAT_MPIE   = 7;
   localparam int MSTAT_MPP_HI = 12;
   localparam int MSTAT_MPP_LO = 11;

   localparam logic [1:0] PRIV_M = 2'b11;
   localparam logic [1:0] PRIV_U = 2'b00;

   // mstatus image written on trap entry: stack MIE into MPIE, record the
   // privilege the trap came from
   function automatic logic [31:0] enter_mstatus(input logic [31:0] s,
                                                 input logic [1:0]  p);
      logic [31:0] r;
      r = s;
      r[MSTAT_MPIE] = s[MSTAT_MIE];
      r[MSTAT_MIE]  = 1'b0;
      r[MSTAT_MPP_HI:MSTAT_MPP_LO] = p;
      return r;
   endfunction

   // mstatus image written on mret: pop MPIE back into MIE, MPP drops to U
   function automatic logic [31:0] return_mstatus(input logic [31:0] s);
      logic [31:0] r;
      r = s;
      r[MSTAT_MIE]  = s[MSTAT_MPIE];
      r[MSTAT_MPIE] = 1'b1;
      r[MSTAT_MPP_HI:MSTAT_MPP_LO] = PRIV_U;
      return r;
   endfunction

   // only M and U exist; reserved MPP encodings collapse to U
   function automatic logic [1:0] mpp_to_priv(input logic [1:0] mpp);
      return (mpp == PRIV_M) ? PRIV_M : PRIV_U;
   endfunction

endpackage

// File: rtl/trap_int_prio.sv
// Fixed-priority interrupt selector: MEI > MSI > MTI, all other pending bits
// are ignored.
module trap_int_prio
   import trap_pkg::*;
(
   input  logic [31:0] int_pend,
   output logic        valid,
   output logic [4:0]  code
);

   // bits other than the three machine interrupt lines are deliberately unused
   logic unused_pend;
   assign unused_pend = ^int_pend;

   // priority pick of the highest pending machine interrupt
   always_comb begin
      valid = 1'b0;
      code  = 5'd0;
      if (int_pend[CAUSE_MEI]) begin
         valid = 1'b1;
         code  = CAUSE_MEI;
      end else if (int_pend[CAUSE_MSI]) begin
         valid = 1'b1;
         code  = CAUSE_MSI;
      end else if (int_pend[CAUSE_MTI]) begin
         valid = 1'b1;
         code  = CAUSE_MTI;
      end
   end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer. Arbitrates exception / interrupt / mret while
// idle, then emits the CSR write strobes, flush and PC redirect.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | arbitrate requests; latch CSR data and redirect target
//   ENTER    | write mstatus/mepc/mcause/mtval, flush; priv -> M
//   RETURN   | write mstatus, flush; priv -> decoded MPP
//   REDIRECT | redirect_valid_o for one cycle, then back to IDLE
module trap_ctrl
   import trap_pkg::*;
#(
   parameter int          XLEN     = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] mstat_i,
   input  logic [XLEN-1:0] mie_i,
   input  logic [XLEN-1:0] mip_i,
   input  logic [XLEN-1:0] mtvec_i,
   input  logic [XLEN-1:0] mepc_i,
   input  logic            exc_valid_i,
   input  logic [4:0]      exc_cause_i,
   input  logic [XLEN-1:0] exc_pc_i,
   input  logic [XLEN-1:0] exc_tval_i,
   input  logic [XLEN-1:0] int_pc_i,
   input  logic            mret_i,
   output logic            stall_o,
   output logic            flush_o,
   output logic            mstat_we_o,
   output logic [XLEN-1:0] mstat_wd_o,
   output logic            mepc_we_o,
   output logic [XLEN-1:0] mepc_wd_o,
   output logic            mcause_we_o,
   output logic [XLEN-1:0] mcause_wd_o,
   output logic            mtval_we_o,
   output logic [XLEN-1:0] mtval_wd_o,
   output logic            redirect_valid_o,
   output logic [XLEN-1:0] redirect_pc_o,
   output logic [1:0]      priv_o
);

   trap_state_e     state_q;
   logic [1:0]      priv_q;
   logic [1:0]      ret_priv_q;
   logic [XLEN-1:0] mstat_wd_q;
   logic [XLEN-1:0] mepc_wd_q;
   logic [XLEN-1:0] mcause_wd_q;
   logic [XLEN-1:0] mtval_wd_q;
   logic [XLEN-1:0] redirect_pc_q;

   logic [XLEN-1:0] int_pend;
   logic            int_valid;
   logic [4:0]      int_code;
   logic [XLEN-1:0] tvec_base;
   logic [XLEN-1:0] int_target;

   // saved PCs are word aligned, so their low two bits never reach mepc
   logic unused_pc_lsb;
   assign unused_pc_lsb = ^{exc_pc_i[1:0], int_pc_i[1:0]};

   // in U-mode interrupts are taken regardless of mstatus.MIE
   assign int_pend = mip_i & mie_i
                   & {XLEN{mstat_i[MSTAT_MIE] | (priv_q == PRIV_U)}};

   trap_int_prio u_int_prio (
      .int_pend (int_pend),
      .valid    (int_valid),
      .code     (int_code)
   );

   // exceptions always use the base; only mode 1 vectors interrupts
   assign tvec_base  = {mtvec_i[XLEN-1:2], 2'b00};
   assign int_target = (mtvec_i[1:0] == 2'b01)
                     ? tvec_base + {{(XLEN-7){1'b0}}, int_code, 2'b00}
                     : tvec_base;

   // sequencer: arbitration, data capture and privilege tracking
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         priv_q        <= PRIV_M;
         ret_priv_q    <= PRIV_M;
         mstat_wd_q    <= '0;
         mepc_wd_q     <= '0;
         mcause_wd_q   <= '0;
         mtval_wd_q    <= '0;
         redirect_pc_q <= RESET_PC;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (exc_valid_i) begin
                  state_q       <= S_ENTER;
                  mstat_wd_q    <= enter_mstatus(mstat_i, priv_q);
                  mepc_wd_q     <= {exc_pc_i[XLEN-1:2], 2'b00};
                  mcause_wd_q   <= {1'b0, {(XLEN-6){1'b0}}, exc_cause_i};
                  mtval_wd_q    <= exc_tval_i;
                  redirect_pc_q <= tvec_base;
               end else if (int_valid) begin
                  state_q       <= S_ENTER;
                  mstat_wd_q    <= enter_mstatus(mstat_i, priv_q);
                  mepc_wd_q     <= {int_pc_i[XLEN-1:2], 2'b00};
                  mcause_wd_q   <= {1'b1, {(XLEN-6){1'b0}}, int_code};
                  mtval_wd_q    <= '0;
                  redirect_pc_q <= int_target;
               end else if (mret_i) begin
                  state_q       <= S_RETURN;
                  mstat_wd_q    <= return_mstatus(mstat_i);
                  ret_priv_q    <= mpp_to_priv(mstat_i[MSTAT_MPP_HI:MSTAT_MPP_LO]);
                  redirect_pc_q <= mepc_i;
               end
            end
            S_ENTER: begin
               priv_q  <= PRIV_M;
               state_q <= S_REDIRECT;
            end
            S_RETURN: begin
               priv_q  <= ret_priv_q;
               state_q <= S_REDIRECT;
            end
            S_REDIRECT: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // strobes are pure state decodes so reset kills them in the same cycle
   assign stall_o          = (state_q != S_IDLE);
   assign flush_o          = (state_q == S_ENTER) || (state_q == S_RETURN);
   assign mstat_we_o       = (state_q == S_ENTER) || (state_q == S_RETURN);
   assign mepc_we_o        = (state_q == S_ENTER);
   assign mcause_we_o      = (state_q == S_ENTER);
   assign mtval_we_o       = (state_q == S_ENTER);
   assign redirect_valid_o = (state_q == S_REDIRECT);

   assign mstat_wd_o    = mstat_wd_q;
   assign mepc_wd_o     = mepc_wd_q;
   assign mcause_wd_o   = mcause_wd_q;
   assign mtval_wd_o    = mtval_wd_q;
   assign redirect_pc_o = redirect_pc_q;
   assign priv_o        = priv_q;

endmodule
